// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - Shared widths, RV32I opcodes and optype codes for the ID-stage decoder
//
// Purpose: single source of truth for the decoder's field widths, the major
// opcode constants and the optype numbering seen by the dispatcher, the
// load-store buffer and the ROB.
// Ports: none (package).
package decoder_pkg;

  localparam int OPTYPE_W = 6;
  localparam int REG_W    = 5;
  localparam int XLEN     = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [OPTYPE_W-1:0] {
    OP_NOP   = 6'd0,  OP_LUI  = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL  = 6'd3,
    OP_JALR  = 6'd4,  OP_BEQ  = 6'd5,  OP_BNE   = 6'd6,  OP_BLT  = 6'd7,
    OP_BGE   = 6'd8,  OP_BLTU = 6'd9,  OP_BGEU  = 6'd10, OP_LB   = 6'd11,
    OP_LH    = 6'd12, OP_LW   = 6'd13, OP_LBU   = 6'd14, OP_LHU  = 6'd15,
    OP_SB    = 6'd16, OP_SH   = 6'd17, OP_SW    = 6'd18, OP_ADDI = 6'd19,
    OP_SLTI  = 6'd20, OP_SLTIU= 6'd21, OP_XORI  = 6'd22, OP_ORI  = 6'd23,
    OP_ANDI  = 6'd24, OP_SLLI = 6'd25, OP_SRLI  = 6'd26, OP_SRAI = 6'd27,
    OP_ADD   = 6'd28, OP_SUB  = 6'd29, OP_SLL   = 6'd30, OP_SLT  = 6'd31,
    OP_SLTU  = 6'd32, OP_XOR  = 6'd33, OP_SRL   = 6'd34, OP_SRA  = 6'd35,
    OP_OR    = 6'd36, OP_AND  = 6'd37
  } optype_e;

endpackage

// File: rtl/instr_imm_gen.sv
// rtl/instr_imm_gen.sv - Combinational RV32I immediate generator selected by opcode
//
// Purpose: builds the immediate for every instruction format from the raw
// instruction word. Unrecognised opcodes and R-type yield 0.
// Ports:
//   instr_i  in  XLEN  raw instruction
//   imm_o    out XLEN  sign/zero-extended immediate
module instr_imm_gen
  import decoder_pkg::*;
(
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] imm_o
);

  logic [2:0] funct3;
  assign funct3 = instr_i[14:12];

  always_comb begin
    imm_o = '0;
    case (instr_i[6:0])
      OPC_LUI, OPC_AUIPC: imm_o = {instr_i[31:12], 12'b0};
      OPC_JAL:            imm_o = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20],
                                   instr_i[30:21], 1'b0};
      OPC_JALR, OPC_LOAD: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      OPC_STORE:          imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      OPC_BRANCH:         imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                   instr_i[30:25], instr_i[11:8], 1'b0};
      OPC_OPIMM: begin
        // Shift amounts live in the low immediate bits and are never signed.
        if (funct3 == 3'b001 || funct3 == 3'b101)
          imm_o = {27'b0, instr_i[24:20]};
        else
          imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      default:            imm_o = '0;
    endcase
  end

endmodule

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - Registered RV32I instruction decoder (ID stage)
//
// Purpose: splits an instruction into optype, register indices and immediate,
// flags loads/stores and conditional branches. 1-cycle registered latency.
// Optional feature: DECODER_ILLEGAL_EN registers is_illegal; otherwise it is 0.
// Ports:
//   clk, rst (sync, active-high), rdy (low = hold all outputs)
//   valid_in, instr           - incoming instruction
//   valid_out, is_ls, is_jump - qualifiers / routing flags
//   optype, rd, rs1, rs2, imm - decoded fields
//   is_illegal                - unknown encoding flag
module instr_decoder
  import decoder_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                valid_in,
  input  logic [XLEN-1:0]     instr,
  output logic                valid_out,
  output logic                is_ls,
  output logic                is_jump,
  output logic [OPTYPE_W-1:0] optype,
  output logic [REG_W-1:0]    rd,
  output logic [REG_W-1:0]    rs1,
  output logic [REG_W-1:0]    rs2,
  output logic [XLEN-1:0]     imm,
  output logic                is_illegal
);

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  optype_e             optype_d;
  logic                use_rd, use_rs1, use_rs2;
  logic [XLEN-1:0]     gen_imm;
  logic [XLEN-1:0]     imm_d;
  logic [REG_W-1:0]    rd_d, rs1_d, rs2_d;
  logic                is_ls_d, is_jump_d;

  logic                valid_q, is_ls_q, is_jump_q;
  logic [OPTYPE_W-1:0] optype_q;
  logic [REG_W-1:0]    rd_q, rs1_q, rs2_q;
  logic [XLEN-1:0]     imm_q;

  instr_imm_gen u_imm_gen (
    .instr_i (instr),
    .imm_o   (gen_imm)
  );

  // OP_NOP never results from a legal decode, so it doubles as the unknown marker.
  always_comb begin
    optype_d = OP_NOP;
    use_rd   = 1'b0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    case (opcode)
      OPC_LUI:   begin optype_d = OP_LUI;   use_rd = 1'b1; end
      OPC_AUIPC: begin optype_d = OP_AUIPC; use_rd = 1'b1; end
      OPC_JAL:   begin optype_d = OP_JAL;   use_rd = 1'b1; end
      OPC_JALR: if (funct3 == 3'b000) begin
        optype_d = OP_JALR; use_rd = 1'b1; use_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        case (funct3)
          3'b000: optype_d = OP_BEQ;
          3'b001: optype_d = OP_BNE;
          3'b100: optype_d = OP_BLT;
          3'b101: optype_d = OP_BGE;
          3'b110: optype_d = OP_BLTU;
          3'b111: optype_d = OP_BGEU;
          default: optype_d = OP_NOP;
        endcase
        use_rs1 = (optype_d != OP_NOP);
        use_rs2 = (optype_d != OP_NOP);
      end
      OPC_LOAD: begin
        case (funct3)
          3'b000: optype_d = OP_LB;
          3'b001: optype_d = OP_LH;
          3'b010: optype_d = OP_LW;
          3'b100: optype_d = OP_LBU;
          3'b101: optype_d = OP_LHU;
          default: optype_d = OP_NOP;
        endcase
        use_rd  = (optype_d != OP_NOP);
        use_rs1 = (optype_d != OP_NOP);
      end
      OPC_STORE: begin
        case (funct3)
          3'b000: optype_d = OP_SB;
          3'b001: optype_d = OP_SH;
          3'b010: optype_d = OP_SW;
          default: optype_d = OP_NOP;
        endcase
        use_rs1 = (optype_d != OP_NOP);
        use_rs2 = (optype_d != OP_NOP);
      end
      OPC_OPIMM: begin
        case (funct3)
          3'b000: optype_d = OP_ADDI;
          3'b010: optype_d = OP_SLTI;
          3'b011: optype_d = OP_SLTIU;
          3'b100: optype_d = OP_XORI;
          3'b110: optype_d = OP_ORI;
          3'b111: optype_d = OP_ANDI;
          3'b001: if (funct7 == 7'h00 || funct7 == 7'h20) optype_d = OP_SLLI;
          3'b101: begin
            if (funct7 == 7'h00)      optype_d = OP_SRLI;
            else if (funct7 == 7'h20) optype_d = OP_SRAI;
          end
          default: optype_d = OP_NOP;
        endcase
        use_rd  = (optype_d != OP_NOP);
        use_rs1 = (optype_d != OP_NOP);
      end
      OPC_OP: begin
        // Only funct7[5] is consulted, and only for SUB/SRA.
        case (funct3)
          3'b000: optype_d = funct7[5] ? OP_SUB : OP_ADD;
          3'b001: optype_d = OP_SLL;
          3'b010: optype_d = OP_SLT;
          3'b011: optype_d = OP_SLTU;
          3'b100: optype_d = OP_XOR;
          3'b101: optype_d = funct7[5] ? OP_SRA : OP_SRL;
          3'b110: optype_d = OP_OR;
          default: optype_d = OP_AND;
        endcase
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      default: optype_d = OP_NOP;
    endcase
  end

  assign rd_d      = use_rd  ? instr[11:7]  : '0;
  assign rs1_d     = use_rs1 ? instr[19:15] : '0;
  assign rs2_d     = use_rs2 ? instr[24:20] : '0;
  assign imm_d     = (optype_d == OP_NOP) ? '0 : gen_imm;
  assign is_ls_d   = (optype_d >= OP_LB)  && (optype_d <= OP_SW);
  assign is_jump_d = (optype_d >= OP_BEQ) && (optype_d <= OP_BGEU);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      is_ls_q   <= 1'b0;
      is_jump_q <= 1'b0;
      optype_q  <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
    end else if (rdy) begin
      valid_q   <= valid_in;
      is_ls_q   <= is_ls_d;
      is_jump_q <= is_jump_d;
      optype_q  <= optype_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      imm_q     <= imm_d;
    end
  end

  assign valid_out = valid_q;
  assign is_ls     = is_ls_q;
  assign is_jump   = is_jump_q;
  assign optype    = optype_q;
  assign rd        = rd_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign imm       = imm_q;

`ifdef DECODER_ILLEGAL_EN
  logic illegal_d, illegal_q;
  assign illegal_d = (optype_d == OP_NOP);

  always_ff @(posedge clk) begin
    if (rst)      illegal_q <= 1'b0;
    else if (rdy) illegal_q <= illegal_d;
  end

  assign is_illegal = illegal_q;
`else
  assign is_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_instr_decoder.sv
// tb/tb_instr_decoder.sv - Self-checking bench for instr_decoder
module tb_instr_decoder;

  logic        clk = 1'b0;
  logic        rst, rdy, valid_in;
  logic [31:0] instr;
  logic        valid_out, is_ls, is_jump, is_illegal;
  logic [5:0]  optype;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .valid_in   (valid_in),
    .instr      (instr),
    .valid_out  (valid_out),
    .is_ls      (is_ls),
    .is_jump    (is_jump),
    .optype     (optype),
    .rd         (rd),
    .rs1        (rs1),
    .rs2        (rs2),
    .imm        (imm),
    .is_illegal (is_illegal)
  );

  // Mnemonic table: opcode, funct3 (-1 = any), funct7 rule, optype, format.
  // funct7 rule: 0 any, 1 bit5=0, 2 bit5=1, 3 0x00|0x20, 4 ==0x00, 5 ==0x20
  // format: 0 U, 1 J, 2 I, 3 shift-imm, 4 B, 5 S, 6 R
  typedef struct { int opc; int f3; int f7k; int opt; int fmt; } ent_t;
  ent_t tbl[$];

  typedef struct {
    logic v, ls, jmp, ill;
    logic [5:0] opt;
    logic [4:0] rd, rs1, rs2;
    logic [31:0] imm;
  } res_t;
  res_t exp_q;

  task automatic add(input int opc, input int f3, input int f7k, input int opt, input int fmt);
    ent_t e;
    e.opc = opc; e.f3 = f3; e.f7k = f7k; e.opt = opt; e.fmt = fmt;
    tbl.push_back(e);
  endtask

  function automatic bit f7_ok(input int k, input logic [6:0] f7);
    case (k)
      1: return f7[5] == 1'b0;
      2: return f7[5] == 1'b1;
      3: return f7 == 7'h00 || f7 == 7'h20;
      4: return f7 == 7'h00;
      5: return f7 == 7'h20;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] sext(input longint v, input int bits);
    longint r;
    r = (v >= (longint'(1) << (bits - 1))) ? v - (longint'(1) << bits) : v;
    return r[31:0];
  endfunction

  function automatic res_t decode(input logic [31:0] ins);
    res_t r;
    int   hit = -1;
    int   fmt;
    r.v = 0; r.ls = 0; r.jmp = 0; r.ill = 0;
    r.opt = 0; r.rd = 0; r.rs1 = 0; r.rs2 = 0; r.imm = 0;
    foreach (tbl[k])
      if (hit < 0 && tbl[k].opc == int'(ins[6:0]) &&
          (tbl[k].f3 < 0 || tbl[k].f3 == int'(ins[14:12])) &&
          f7_ok(tbl[k].f7k, ins[31:25]))
        hit = k;
    if (hit < 0) begin
      r.ill = 1;
      return r;
    end
    fmt   = tbl[hit].fmt;
    r.opt = 6'(tbl[hit].opt);
    r.rd  = (fmt inside {0, 1, 2, 3, 6}) ? ins[11:7]  : 5'd0;
    r.rs1 = (fmt inside {2, 3, 4, 5, 6}) ? ins[19:15] : 5'd0;
    r.rs2 = (fmt inside {4, 5, 6})       ? ins[24:20] : 5'd0;
    case (fmt)
      0: r.imm = longint'(ins[31:12]) * 4096;
      1: r.imm = sext(longint'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
      2: r.imm = sext(longint'(ins[31:20]), 12);
      3: r.imm = 32'(ins[24:20]);
      4: r.imm = sext(longint'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
      5: r.imm = sext(longint'({ins[31:25], ins[11:7]}), 12);
      default: r.imm = 0;
    endcase
    r.ls  = (tbl[hit].opt >= 11 && tbl[hit].opt <= 18);
    r.jmp = (tbl[hit].opt >= 5  && tbl[hit].opt <= 10);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
    n_assert++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  task automatic check_all(input string tag);
    logic exp_ill;
`ifdef DECODER_ILLEGAL_EN
    exp_ill = exp_q.ill;
`else
    exp_ill = 1'b0;
`endif
    chk({tag, ".valid"},   32'(valid_out),  32'(exp_q.v));
    chk({tag, ".is_ls"},   32'(is_ls),      32'(exp_q.ls));
    chk({tag, ".is_jump"}, 32'(is_jump),    32'(exp_q.jmp));
    chk({tag, ".optype"},  32'(optype),     32'(exp_q.opt));
    chk({tag, ".rd"},      32'(rd),         32'(exp_q.rd));
    chk({tag, ".rs1"},     32'(rs1),        32'(exp_q.rs1));
    chk({tag, ".rs2"},     32'(rs2),        32'(exp_q.rs2));
    chk({tag, ".imm"},     imm,             exp_q.imm);
    chk({tag, ".illegal"}, 32'(is_illegal), 32'(exp_ill));
  endtask

  // Advance one clock, update the reference register image from the inputs
  // that were applied, then compare #1 after the edge.
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst) begin
      exp_q.v = 0; exp_q.ls = 0; exp_q.jmp = 0; exp_q.ill = 0;
      exp_q.opt = 0; exp_q.rd = 0; exp_q.rs1 = 0; exp_q.rs2 = 0; exp_q.imm = 0;
    end else if (rdy) begin
      exp_q   = decode(instr);
      exp_q.v = valid_in;
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic [31:0] ins, input logic v);
    instr = ins; valid_in = v;
  endtask

  logic [6:0] opc_list [9];

  initial begin
    add(7'h37, -1, 0, 1, 0);  add(7'h17, -1, 0, 2, 0);
    add(7'h6F, -1, 0, 3, 1);  add(7'h67,  0, 0, 4, 2);
    add(7'h63, 0, 0, 5, 4);   add(7'h63, 1, 0, 6, 4);   add(7'h63, 4, 0, 7, 4);
    add(7'h63, 5, 0, 8, 4);   add(7'h63, 6, 0, 9, 4);   add(7'h63, 7, 0, 10, 4);
    add(7'h03, 0, 0, 11, 2);  add(7'h03, 1, 0, 12, 2);  add(7'h03, 2, 0, 13, 2);
    add(7'h03, 4, 0, 14, 2);  add(7'h03, 5, 0, 15, 2);
    add(7'h23, 0, 0, 16, 5);  add(7'h23, 1, 0, 17, 5);  add(7'h23, 2, 0, 18, 5);
    add(7'h13, 0, 0, 19, 2);  add(7'h13, 2, 0, 20, 2);  add(7'h13, 3, 0, 21, 2);
    add(7'h13, 4, 0, 22, 2);  add(7'h13, 6, 0, 23, 2);  add(7'h13, 7, 0, 24, 2);
    add(7'h13, 1, 3, 25, 3);  add(7'h13, 5, 4, 26, 3);  add(7'h13, 5, 5, 27, 3);
    add(7'h33, 0, 1, 28, 6);  add(7'h33, 0, 2, 29, 6);  add(7'h33, 1, 0, 30, 6);
    add(7'h33, 2, 0, 31, 6);  add(7'h33, 3, 0, 32, 6);  add(7'h33, 4, 0, 33, 6);
    add(7'h33, 5, 1, 34, 6);  add(7'h33, 5, 2, 35, 6);  add(7'h33, 6, 0, 36, 6);
    add(7'h33, 7, 0, 37, 6);
    opc_list = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

    rst = 1'b1; rdy = 1'b1; valid_in = 1'b0; instr = 32'h0;
    tick("reset0");
    tick("reset1");
    chk("reset.optype_const", 32'(optype), 32'd0);
    chk("reset.valid_const",  32'(valid_out), 32'd0);

    rst = 1'b0;
    drive(32'h00500093, 1'b1);                       // addi x1,x0,5
    tick("addi");
    chk("addi.opt_c", 32'(optype), 32'd19);
    chk("addi.rd_c",  32'(rd), 32'd1);
    chk("addi.imm_c", imm, 32'h5);
    chk("addi.v_c",   32'(valid_out), 32'd1);

    drive(32'hFE20AE23, 1'b1);                       // sw x2,-4(x1)
    tick("sw");
    chk("sw.opt_c", 32'(optype), 32'd18);
    chk("sw.imm_c", imm, 32'hFFFFFFFC);
    chk("sw.ls_c",  32'(is_ls), 32'd1);

    drive(32'hFE208CE3, 1'b1);                       // beq x1,x2,-8
    tick("beq");
    chk("beq.opt_c",  32'(optype), 32'd5);
    chk("beq.imm_c",  imm, 32'hFFFFFFF8);
    chk("beq.jmp_c",  32'(is_jump), 32'd1);

    drive(32'h123452B7, 1'b1);                       // lui x5,0x12345
    tick("lui");
    chk("lui.imm_c", imm, 32'h12345000);
    chk("lui.rd_c",  32'(rd), 32'd5);

    drive(32'h40725193, 1'b0);                       // srai x3,x4,7, not valid
    tick("srai");
    chk("srai.opt_c", 32'(optype), 32'd27);
    chk("srai.imm_c", imm, 32'd7);
    chk("srai.v_c",   32'(valid_out), 32'd0);

    rdy = 1'b0;
    drive(32'h00500093, 1'b1);
    tick("hold0"); tick("hold1"); tick("hold2");
    chk("hold.opt_c", 32'(optype), 32'd27);
    chk("hold.rs1_c", 32'(rs1), 32'd4);

    rdy = 1'b1;
    drive(32'hFFFFFFFF, 1'b1);
    tick("allones");
    chk("allones.opt_c", 32'(optype), 32'd0);
    chk("allones.imm_c", imm, 32'd0);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] r;
      int sel;
      r = $urandom;
      if ($urandom_range(0, 99) < 85) r[6:0] = opc_list[$urandom_range(0, 8)];
      sel = $urandom_range(0, 2);
      if (sel == 0)      r[31:25] = 7'h00;
      else if (sel == 1) r[31:25] = 7'h20;
      rdy = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 49) == 0);
      drive(r, 1'($urandom_range(0, 1)));
      tick("rand");
    end

    rst = 1'b0; rdy = 1'b1;
    drive(32'h00500093, 1'b1);
    tick("pre_rst");
    rst = 1'b1; rdy = 1'b0;
    tick("rst_over_rdy");
    chk("rst_over_rdy.v_c", 32'(valid_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_decoder.md
Name: instr_decoder

Overview:
- Registered RV32I instruction decoder in the ID stage, between the instruction fetcher and the dispatcher.
- Splits a 32-bit instruction into an operation type, register indices and a sign-extended immediate.
- Flags loads/stores (routed to the load-store buffer) and conditional branches (tracked by the ROB).
- Outputs are registered with 1-cycle latency.

Parameters:
- OPTYPE_W, 6, width of the optype code.
- XLEN, 32, instruction/immediate width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low = stall, all outputs hold
- valid_in  in  1  instr is valid this cycle
- instr  in  32  raw instruction
- valid_out  out  1  decoded fields valid
- is_ls  out  1  load or store
- is_jump  out  1  conditional branch (BEQ..BGEU) only
- optype  out  6  operation code (see package)
- rd  out  5  destination register
- rs1  out  5  source register 1
- rs2  out  5  source register 2
- imm  out  32  sign-extended immediate
- is_illegal  out  1  unrecognised encoding (see Optional Feature)

Behaviour:
- Reset (rst=1 at posedge): all outputs become 0 (optype=NOP=0). rst has priority over rdy.
- rdy=0 and rst=0: all outputs hold.
- Otherwise, each posedge: valid_out<=valid_in and all fields are decoded from instr. Fields are decoded even when valid_in=0; consumers qualify them with valid_out.
- Optype codes: NOP0 LUI1 AUIPC2 JAL3 JALR4 BEQ5 BNE6 BLT7 BGE8 BLTU9 BGEU10 LB11 LH12 LW13 LBU14 LHU15 SB16 SH17 SW18 ADDI19 SLTI20 SLTIU21 XORI22 ORI23 ANDI24 SLLI25 SRLI26 SRAI27 ADD28 SUB29 SLL30 SLT31 SLTU32 XOR33 SRL34 SRA35 OR36 AND37.
- Selection is by opcode, funct3 and funct7[5]; funct7[5] distinguishes SUB/SRA/SRAI only. SLLI/SRLI/SRAI require funct7[6:0] to be 0x00 or 0x20.
- Unused register fields are forced to 0:
  - rd=0 for stores and branches.
  - rs1=0 for LUI, AUIPC and JAL.
  - rs2=0 for everything except R-type, stores and branches.
  - A zero index reads the always-ready x0.
- Immediates:
  - I-type: instr[31:20] sign-extended.
  - Shift-immediates: instr[24:20] zero-extended.
  - S-type: {instr[31:25],instr[11:7]} sign-extended.
  - B-type: {instr[31],instr[7],instr[30:25],instr[11:8],0} sign-extended.
  - U-type: {instr[31:12],12'b0}.
  - J-type: {instr[31],instr[19:12],instr[20],instr[30:21],0} sign-extended.
  - R-type: 0.
- is_ls=1 exactly for optype 11..18. is_jump=1 exactly for optype 5..10.
- Unknown opcode or funct combination: optype=NOP, rd=rs1=rs2=0, imm=0, is_ls=is_jump=0; valid_out still follows valid_in.

Optional Feature:
- Macro DECODER_ILLEGAL_EN.
- Defined: is_illegal is registered like the other outputs and is 1 when the decode falls into the unknown case. It resets to 0.
- Undefined: is_illegal is tied to constant 0. All other behaviour is identical in both builds.

Decomposition:
- Package decoder_pkg holds:
  - opcode constants: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011;
  - all optype codes;
  - widths OPTYPE_W=6, REG_W=5, XLEN=32.
- One sub-module is natural: instr_imm_gen, a combinational immediate generator selected by opcode.

Test Plan:
- 0x00500093 (addi x1,x0,5) -> optype 19, rd 1, rs1 0, rs2 0, imm 0x00000005, is_ls 0, is_jump 0, valid_out 1 one cycle later.
- 0xFE20AE23 (sw x2,-4(x1)) -> optype 18, rd 0, rs1 1, rs2 2, imm 0xFFFFFFFC, is_ls 1.
- 0xFE208CE3 (beq x1,x2,-8) -> optype 5, rd 0, rs1 1, rs2 2, imm 0xFFFFFFF8, is_jump 1.
- 0x123452B7 (lui x5,0x12345) -> optype 1, rd 5, rs1 0, imm 0x12345000; then 0x40725193 (srai x3,x4,7) -> optype 27, rd 3, rs1 4, imm 7.
- 0xFFFFFFFF -> optype 0, all fields 0; is_illegal 1 only with DECODER_ILLEGAL_EN.
- Control: rdy=0 for 3 cycles with new instr -> outputs hold; rst=1 with rdy=0 -> valid_out 0 next cycle.
